// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode values, instruction field layout and the
// sequencer state encoding. Imported by the sequencer and by the ALU.
package cpu_defs;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OpNop   = 4'h0;
    localparam opcode_t OpAluLo = 4'h1;
    localparam opcode_t OpAluHi = 4'h7;
    localparam opcode_t OpLoad  = 4'h8;
    localparam opcode_t OpStore = 4'h9;
    localparam opcode_t OpHalt  = 4'hF;

    // Instruction word: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
    typedef struct packed {
        opcode_t    opcode;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_t;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRead = 3'd1,
        StExec = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StHalt = 3'd5
    } state_e;

    function automatic logic is_alu(input opcode_t op);
        return (op >= OpAluLo) && (op <= OpAluHi);
    endfunction

    function automatic logic is_mem(input opcode_t op);
        return (op == OpLoad) || (op == OpStore);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and its environment (fetch, register
// file, ALU, data memory).
//   instr_valid/instr/instr_ready : instruction handshake
//   reg1_*/reg2_*                 : register-file read ports (enable + index)
//   reg3_write/reg3_addr          : register-file write-back strobe + index
//   alu_op/alu_start/alu_done     : ALU control and completion
//   mem_read/mem_write/mem_done   : data-memory requests and completion
//   halted/fault                  : status
// master = sequencer side, slave = environment side.
interface instr_sequencer_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        reg1_read;
    logic        reg2_read;
    logic        reg3_write;
    logic [3:0]  reg1_addr;
    logic [3:0]  reg2_addr;
    logic [3:0]  reg3_addr;
    logic [3:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic        mem_read;
    logic        mem_write;
    logic        mem_done;
    logic        halted;
    logic        fault;

    modport master (
        input  instr_valid, instr, alu_done, mem_done,
        output instr_ready, reg1_read, reg2_read, reg3_write, reg1_addr, reg2_addr,
               reg3_addr, alu_op, alu_start, mem_read, mem_write, halted, fault
    );

    modport slave (
        output instr_valid, instr, alu_done, mem_done,
        input  instr_ready, reg1_read, reg2_read, reg3_write, reg1_addr, reg2_addr,
               reg3_addr, alu_op, alu_start, mem_read, mem_write, halted, fault
    );
endinterface

// File: rtl/wait_timer.sv
// Wait-cycle counter for the sequencer's EXEC/MEM states.
//   clk, rst : clock, synchronous active-high reset
//   clear    : hold the count at zero
//   enable   : count one waiting cycle
//   limit    : number of waiting cycles allowed
//   expired  : current enabled cycle is the limit-th one
module wait_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != limit)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the cycle whose increment reaches limit; the caller lets a done
    // arriving in that same cycle win over the timeout.
    assign expired = enable && ((count_q + W'(1)) == limit);
endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts one 16-bit instruction at a time and steps it
// through register read, ALU execute or memory access, and write-back.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_sequencer_if.master (handshake, register file, ALU, memory,
//              halted/fault status)
// All outputs decode registered state (state_q, ir_q, fault_q) only.
module instr_sequencer
    import cpu_defs::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input logic               clk,
    input logic               rst,
    instr_sequencer_if.master bus
);
    localparam int unsigned TimerW = $clog2(WAIT_LIMIT + 1);

    state_e  state_q, state_d;
    instr_t  ir_q, ir_d;
    instr_t  in_w;
    opcode_t ir_op;
    logic    fault_q, fault_d;
    logic    ready, accept, waiting, expired;

    assign in_w    = instr_t'(bus.instr);
    assign ir_op   = ir_q.opcode;
    assign ready   = (state_q == StIdle) && !fault_q;
    assign accept  = bus.instr_valid && ready;
    assign waiting = (state_q == StExec) || (state_q == StMem);

    wait_timer #(
        .W(TimerW)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!waiting),
        .enable (waiting),
        .limit  (TimerW'(WAIT_LIMIT)),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    ir_d = in_w;
                    if (is_alu(in_w.opcode) || is_mem(in_w.opcode)) begin
                        state_d = StRead;
                    end else if (in_w.opcode == OpHalt) begin
                        state_d = StHalt;
                    end else if (in_w.opcode != OpNop) begin
                        fault_d = 1'b1;
                    end
                end
            end
            StRead: state_d = is_alu(ir_op) ? StExec : StMem;
            StExec: begin
                if (bus.alu_done) begin
                    state_d = StWb;
                end else if (expired) begin
                    state_d = StIdle;
                    fault_d = 1'b1;
                end
            end
            StMem: begin
                if (bus.mem_done) begin
                    state_d = (ir_op == OpLoad) ? StWb : StIdle;
                end else if (expired) begin
                    state_d = StIdle;
                    fault_d = 1'b1;
                end
            end
            StWb:    state_d = StIdle;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ir_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        bus.instr_ready = ready;
        bus.fault       = fault_q;
        bus.halted      = 1'b0;
        bus.reg1_read   = 1'b0;
        bus.reg2_read   = 1'b0;
        bus.reg3_write  = 1'b0;
        bus.reg1_addr   = 4'h0;
        bus.reg2_addr   = 4'h0;
        bus.reg3_addr   = 4'h0;
        bus.alu_op      = 4'h0;
        bus.alu_start   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        unique case (state_q)
            StRead, StExec, StMem: begin
                if (is_alu(ir_op)) begin
                    bus.reg1_read = 1'b1;
                    bus.reg1_addr = ir_q.rs1;
                    bus.reg2_read = 1'b1;
                    bus.reg2_addr = ir_q.rs2;
                    bus.alu_op    = ir_op;
                    bus.alu_start = (state_q == StRead);
                end else begin
                    // Port 2 carries the memory address (rs1); STORE reads its data from rd.
                    bus.reg2_read = 1'b1;
                    bus.reg2_addr = ir_q.rs1;
                    if (ir_op == OpStore) begin
                        bus.reg1_read = 1'b1;
                        bus.reg1_addr = ir_q.rd;
                    end
                    bus.mem_read  = (state_q == StMem) && (ir_op == OpLoad);
                    bus.mem_write = (state_q == StMem) && (ir_op == OpStore);
                end
            end
            StWb: begin
                bus.reg3_write = 1'b1;
                bus.reg3_addr  = ir_q.rd;
                if (is_alu(ir_op)) begin
                    bus.alu_op = ir_op;
                end
            end
            StHalt:  bus.halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised scoreboard bench for instr_sequencer. The driver plans each
// instruction's expected strobe cycles into a queue; a monitor pops one entry
// per cycle in which the DUT shows any strobe.
module tb_instr_sequencer;
    localparam int unsigned L = 4;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    instr_sequencer_if bus ();

    instr_sequencer #(
        .WAIT_LIMIT(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic       r1, r2, w, st, mrd, mwr, opc;
        logic [3:0] a1, a2, a3, op;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected strobe cycle; addresses/op only matter where the matching enable is set.
    function automatic snap_t mk(input logic r1, input logic [3:0] a1, input logic r2,
                                 input logic [3:0] a2, input logic w, input logic [3:0] a3,
                                 input logic st, input logic mrd, input logic mwr,
                                 input logic opc, input logic [3:0] op);
        snap_t s;
        s.r1 = r1; s.r2 = r2; s.w = w; s.st = st; s.mrd = mrd; s.mwr = mwr; s.opc = opc;
        s.a1 = r1 ? a1 : 4'h0;
        s.a2 = r2 ? a2 : 4'h0;
        s.a3 = w ? a3 : 4'h0;
        s.op = opc ? op : 4'h0;
        return s;
    endfunction

    function automatic snap_t observe(input snap_t e);
        snap_t a;
        a.r1 = bus.reg1_read; a.r2 = bus.reg2_read; a.w = bus.reg3_write;
        a.st = bus.alu_start; a.mrd = bus.mem_read; a.mwr = bus.mem_write; a.opc = e.opc;
        a.a1 = e.r1 ? bus.reg1_addr : 4'h0;
        a.a2 = e.r2 ? bus.reg2_addr : 4'h0;
        a.a3 = e.w ? bus.reg3_addr : 4'h0;
        a.op = e.opc ? bus.alu_op : 4'h0;
        return a;
    endfunction

    // Reference: one read cycle, n waiting cycles, then an optional write-back.
    function automatic void plan(input logic [15:0] ins, input int n, input bit wb);
        logic [3:0] opc, rd, rs1, rs2;
        {opc, rd, rs1, rs2} = ins;
        if (opc >= 4'h1 && opc <= 4'h7) begin
            exp_q.push_back(mk(1'b1, rs1, 1'b1, rs2, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, opc));
            for (int i = 0; i < n; i++)
                exp_q.push_back(mk(1'b1, rs1, 1'b1, rs2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, opc));
            if (wb)
                exp_q.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, rd, 1'b0, 1'b0, 1'b0, 1'b1, opc));
        end else if (opc == 4'h8) begin
            exp_q.push_back(mk(1'b0, 4'h0, 1'b1, rs1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
            for (int i = 0; i < n; i++)
                exp_q.push_back(mk(1'b0, 4'h0, 1'b1, rs1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0));
            if (wb)
                exp_q.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, rd, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
        end else if (opc == 4'h9) begin
            exp_q.push_back(mk(1'b1, rd, 1'b1, rs1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
            for (int i = 0; i < n; i++)
                exp_q.push_back(mk(1'b1, rd, 1'b1, rs1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0));
        end
    endfunction

    // Clock edges from acceptance until instr_ready returns, done on wait cycle d.
    function automatic int lat(input logic [3:0] opc, input int d);
        if (opc == 4'h0) return 0;
        if (opc == 4'h9) return d + 1;
        return d + 2;
    endfunction

    task automatic monitor();
        snap_t e;
        snap_t a;
        forever begin
            @(negedge clk);
            if (mon_en && (bus.reg1_read || bus.reg2_read || bus.reg3_write || bus.alu_start ||
                           bus.mem_read || bus.mem_write)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got r1=%b r2=%b w=%b st=%b mrd=%b mwr=%b expected none at %0t",
                             bus.reg1_read, bus.reg2_read, bus.reg3_write, bus.alu_start,
                             bus.mem_read, bus.mem_write, $time);
                end else begin
                    e = exp_q.pop_front();
                    a = observe(e);
                    check("strobes", 64'(a), 64'(e));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.instr    = 16'($urandom);
            bus.alu_done = 1'($urandom);
            bus.mem_done = 1'($urandom);
            tick();
        end
        bus.alu_done = 1'b0;
        bus.mem_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_outputs",
              64'({bus.instr_ready, bus.halted, bus.fault, bus.reg1_read, bus.reg2_read,
                   bus.reg3_write, bus.alu_start, bus.mem_read, bus.mem_write, bus.reg1_addr,
                   bus.reg2_addr, bus.reg3_addr, bus.alu_op}),
              64'({1'b1, 24'h0}));
        check("queue_empty_after_reset", 64'(exp_q.size()), 64'd0);
    endtask

    // rst_at >= 0: assert reset during that waiting cycle (d must exceed L).
    task automatic run(input logic [15:0] ins, input int d, input int rst_at);
        logic [3:0] opc;
        int         n, edges;
        bit         alu, mem, ok;
        opc   = ins[15:12];
        alu   = (opc >= 4'h1 && opc <= 4'h7);
        mem   = (opc == 4'h8 || opc == 4'h9);
        ok    = (d <= int'(L)) && (rst_at < 0);
        n     = (rst_at >= 0) ? rst_at : ((d <= int'(L)) ? d : int'(L));
        edges = 0;
        while (bus.instr_ready !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        check("ready_before_issue", 64'(bus.instr_ready), 64'd1);
        if (bus.instr_ready !== 1'b1) begin
            do_reset();
            return;
        end
        plan(ins, n, ok && (alu || opc == 4'h8));
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        tick();
        if (alu || mem || opc == 4'h0) begin
            bus.instr_valid = 1'b0;
            bus.instr       = 16'($urandom);
        end
        if (opc == 4'h0) begin
            check("nop_ready", 64'(bus.instr_ready), 64'd1);
        end else if (alu || mem) begin
            for (int k = 0; k <= n; k++) begin
                if (alu) begin
                    bus.alu_done = (k == d) || (k == 0 && $urandom_range(1) == 1);
                    bus.mem_done = 1'($urandom);
                end else begin
                    bus.mem_done = (k == d) || (k == 0 && $urandom_range(1) == 1);
                    bus.alu_done = 1'($urandom);
                end
                if (rst_at >= 0 && k == rst_at) rst = 1'b1;
                tick();
            end
            bus.alu_done = 1'b0;
            bus.mem_done = 1'b0;
            edges = n + 1;
            if (rst_at >= 0) begin
                rst = 1'b0;
                check("reset_mid_op",
                      64'({bus.mem_read, bus.mem_write, bus.reg3_write, bus.instr_ready}),
                      64'(4'b0001));
                idle_gap(3);
                check("no_writeback_after_reset", 64'(exp_q.size()), 64'd0);
            end else if (ok) begin
                while (bus.instr_ready !== 1'b1 && edges < 40) begin
                    tick();
                    edges++;
                end
                check("latency", 64'(edges), 64'(lat(opc, d)));
            end else begin
                check("timeout_fault", 64'({bus.fault, bus.instr_ready}), 64'(2'b10));
                idle_gap(3);
                check("fault_sticky", 64'({bus.fault, bus.instr_ready}), 64'(2'b10));
                do_reset();
            end
        end else if (opc == 4'hF) begin
            check("halted", 64'({bus.halted, bus.instr_ready}), 64'(2'b10));
            for (int i = 0; i < 4; i++) begin
                bus.instr = 16'($urandom);
                tick();
            end
            check("halt_hold", 64'({bus.halted, bus.instr_ready, bus.fault}), 64'(3'b100));
            bus.instr_valid = 1'b0;
            do_reset();
        end else begin
            check("illegal_fault", 64'({bus.fault, bus.instr_ready, bus.halted}), 64'(3'b100));
            for (int i = 0; i < 4; i++) begin
                bus.instr = 16'($urandom);
                tick();
            end
            check("illegal_hold", 64'({bus.fault, bus.instr_ready, bus.halted}), 64'(3'b100));
            bus.instr_valid = 1'b0;
            do_reset();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int          r, d, rst_at;
        logic [3:0]  op;
        logic [15:0] ins;
        fork
            monitor();
        join_none
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0;
        bus.alu_done    = 1'b0;
        bus.mem_done    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_reset();

        run(16'h1123, 1, -1);               // ADD, done on first wait cycle
        run(16'h8450, 3, -1);               // LOAD, mem_done after 3 cycles
        run(16'h9670, 2, -1);               // STORE
        run(16'h2345, int'(L), -1);         // done on the expiring cycle
        run(16'h0000, 1, -1);               // NOP
        run(16'h3abc, int'(L) + 5, -1);     // ALU timeout
        run(16'h8450, int'(L) + 5, 2);      // reset mid-MEM
        run(16'hF000, 1, -1);               // HALT
        run(16'hA000, 1, -1);               // illegal

        for (int i = 0; i < 150; i++) begin
            idle_gap($urandom_range(2));
            r = $urandom_range(99);
            if (r < 6)       op = 4'h0;
            else if (r < 56) op = 4'($urandom_range(7, 1));
            else if (r < 72) op = 4'h8;
            else if (r < 88) op = 4'h9;
            else if (r < 94) op = 4'($urandom_range(14, 10));
            else             op = 4'hF;
            ins    = {op, 12'($urandom)};
            d      = $urandom_range(int'(L) + 2, 1);
            rst_at = -1;
            if ((op == 4'h8 || op == 4'h9) && $urandom_range(9) == 0) begin
                rst_at = $urandom_range(int'(L), 1);
                d      = int'(L) + 10;
            end
            run(ins, d, rst_at);
        end

        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
